// File: rtl/rbm_hidden_sched_if.sv
// -----------------------------------------------------------------------------
// rbm_hidden_sched_if
// Purpose : bundle of the signals between the hidden-pass sequencer and the
//           RBM core / hidden-probability buffer.
// Signals :
//   col_idx    - current hidden index j (weight column / bias address)
//   core_start - one-cycle start pulse to the core
//   core_busy  - core busy
//   core_p     - core result p_j (Q0.16)
//   p_wr_en    - hidden-probability buffer write strobe
//   p_wr_addr  - buffer write address (= j)
//   p_wr_data  - registered copy of core_p
// Modports: master = sequencer side, slave = core/buffer side.
//
// Handshake: the sequencer issues a single-cycle core_start; the core answers
// by raising core_busy at some later cycle and lowering it when core_p is
// valid. core_p is sampled on the first cycle core_busy is seen low again.
// The buffer takes p_wr_addr/p_wr_data on every cycle p_wr_en is high; there
// is no backpressure in either direction.
// -----------------------------------------------------------------------------
interface rbm_hidden_sched_if #(
  parameter int H_MAX = 64,
  parameter int P_W   = 16
);
  localparam int HW = $clog2(H_MAX);

  logic [HW-1:0]  col_idx;
  logic           core_start;
  logic           core_busy;
  logic [P_W-1:0] core_p;
  logic           p_wr_en;
  logic [HW-1:0]  p_wr_addr;
  logic [P_W-1:0] p_wr_data;

  modport master (
    output col_idx, core_start, p_wr_en, p_wr_addr, p_wr_data,
    input  core_busy, core_p
  );

  modport slave (
    input  col_idx, core_start, p_wr_en, p_wr_addr, p_wr_data,
    output core_busy, core_p
  );
endinterface

// File: rtl/rbm_hidden_sched.sv
// -----------------------------------------------------------------------------
// rbm_hidden_sched
// Purpose : hidden-layer pass sequencer for the single-unit RBM core. Walks
//           j = 0..n-1, kicks the core once per unit, waits for it to finish
//           and writes p_j into the hidden-probability buffer.
// Ports   :
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_start         - begin a pass (sampled in IDLE only)
//   i_abort         - cancel a running pass
//   i_num_hidden    - units to process, clamped to H_MAX, sampled at start
//   o_busy          - pass in progress
//   o_done          - one-cycle pulse on normal completion
//   o_aborted       - sticky, set by abort, cleared by next accepted start
//   o_err_timeout   - sticky watchdog flag (0 unless the watchdog is built)
//   o_dbg_state     - current FSM state encoding
//   core_if         - core / buffer signals (master modport)
// Build option: define RBM_SCHED_TIMEOUT_EN to add a 16-bit watchdog on the
//   two WAIT states; on expiry it sets err_timeout and takes the abort path.
// -----------------------------------------------------------------------------
module rbm_hidden_sched #(
  parameter int H_MAX = 64,
  parameter int P_W   = 16,
  localparam int HW   = $clog2(H_MAX)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [HW:0]                i_num_hidden,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_aborted,
  output logic                       o_err_timeout,
  output logic [2:0]                 o_dbg_state,
  rbm_hidden_sched_if.master         core_if
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    KICK      = 3'd2,
    WAIT_RISE = 3'd3,
    WAIT_FALL = 3'd4,
    WRITE     = 3'd5,
    NEXT      = 3'd6
  } state_t;

  localparam logic [HW:0] LP_HMAX = (HW+1)'(H_MAX);
  localparam logic [HW:0] LP_ONE  = (HW+1)'(1);

  state_t         r_state;
  state_t         w_next;
  logic [HW:0]    r_n;
  logic [HW-1:0]  r_j;
  logic [P_W-1:0] r_p;
  logic           r_aborted;
  logic           r_done_zero;

  logic [HW:0]    w_n_clamped;
  logic           w_accept;
  logic           w_is_last;
  logic           w_timeout;
  logic           w_abort_path;
  logic           w_core_start;
  logic           w_wr_en;
  logic           w_done_last;

  assign w_n_clamped  = (i_num_hidden > LP_HMAX) ? LP_HMAX : i_num_hidden;
  assign w_accept     = (r_state == IDLE) && i_start;
  assign w_is_last    = ({1'b0, r_j} == (r_n - LP_ONE));
  // Abort only has an effect while a pass is running; in IDLE start wins.
  assign w_abort_path = (r_state != IDLE) && (i_abort || w_timeout);

`ifdef RBM_SCHED_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_err_timeout;
  logic        w_in_wait;

  assign w_in_wait = (r_state == WAIT_RISE) || (r_state == WAIT_FALL);
  // The counter shows cycles already spent in the current WAIT state, so
  // firing at 0xFFFE exits at the end of the 65535th cycle.
  assign w_timeout = w_in_wait && (r_wdog == 16'hFFFE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      // Reload on every state change, which covers entry to each WAIT state.
      if (w_next != r_state) r_wdog <= '0;
      else if (w_in_wait)    r_wdog <= r_wdog + 16'd1;

      if (w_accept)       r_err_timeout <= 1'b0;
      else if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign w_timeout     = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_core_start = 1'b0;
    w_wr_en      = 1'b0;
    w_done_last  = 1'b0;
    case (r_state)
      IDLE:      if (i_start) w_next = (w_n_clamped == '0) ? IDLE : SETUP;
      SETUP:     w_next = KICK;
      KICK: begin
        w_core_start = 1'b1;
        w_next       = WAIT_RISE;
      end
      WAIT_RISE: if (core_if.core_busy)  w_next = WAIT_FALL;
      WAIT_FALL: if (!core_if.core_busy) w_next = WRITE;
      WRITE: begin
        w_wr_en = 1'b1;
        w_next  = NEXT;
      end
      NEXT: begin
        if (w_is_last) begin
          w_done_last = 1'b1;
          w_next      = IDLE;
        end else begin
          w_next = SETUP;
        end
      end
      default:   w_next = IDLE;
    endcase
    // Abort overrides everything produced above in the same cycle.
    if (w_abort_path) begin
      w_next       = IDLE;
      w_core_start = 1'b0;
      w_wr_en      = 1'b0;
      w_done_last  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n         <= '0;
      r_j         <= '0;
      r_p         <= '0;
      r_aborted   <= 1'b0;
      r_done_zero <= 1'b0;
    end else begin
      r_done_zero <= 1'b0;
      if (w_accept) begin
        r_n         <= w_n_clamped;
        r_j         <= '0;
        r_aborted   <= 1'b0;
        // Empty pass: no core activity, just the done pulse next cycle.
        r_done_zero <= (w_n_clamped == '0);
      end else if (w_abort_path) begin
        r_aborted <= 1'b1;
      end else begin
        if ((r_state == WAIT_FALL) && !core_if.core_busy) r_p <= core_if.core_p;
        if ((r_state == NEXT) && !w_is_last)              r_j <= r_j + 1'b1;
      end
    end
  end

  // done for a normal pass is high during the final NEXT cycle; busy is
  // dropped in that same cycle so the host sees busy fall with done.
  assign o_done      = w_done_last || r_done_zero;
  assign o_busy      = (r_state != IDLE) && !w_done_last;
  assign o_aborted   = r_aborted;
  assign o_dbg_state = r_state;

  assign core_if.col_idx    = r_j;
  assign core_if.core_start = w_core_start;
  assign core_if.p_wr_en    = w_wr_en;
  assign core_if.p_wr_addr  = r_j;
  assign core_if.p_wr_data  = r_p;

endmodule

// File: tb/tb_rbm_hidden_sched.sv
// -----------------------------------------------------------------------------
// tb_rbm_hidden_sched
// Bench for rbm_hidden_sched: behavioural core model with random busy time and
// random results, scoreboard of expected buffer writes, pass-level reference
// (unit count, writes, done latency = sum over units of 5 + busy time).
// -----------------------------------------------------------------------------
module tb_rbm_hidden_sched;
  localparam int H_MAX = 64;
  localparam int P_W   = 16;
  localparam int HW    = 6;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_start;
  logic          i_abort;
  logic [HW:0]   i_num_hidden;
  logic          o_busy;
  logic          o_done;
  logic          o_aborted;
  logic          o_err_timeout;
  logic [2:0]    o_dbg_state;

  rbm_hidden_sched_if #(.H_MAX(H_MAX), .P_W(P_W)) u_if ();

  rbm_hidden_sched #(.H_MAX(H_MAX), .P_W(P_W)) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_num_hidden  (i_num_hidden),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_aborted     (o_aborted),
    .o_err_timeout (o_err_timeout),
    .o_dbg_state   (o_dbg_state),
    .core_if       (u_if)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- core model + scoreboard ----------------
  logic [P_W-1:0] exp_q[$];
  int lat_min   = 1;
  int lat_max   = 1;
  int dead_from = -1;   // kick index from which the core never answers
  bit fixed_p   = 1'b0; // p = 0x1000 + j instead of random
  int kick_cnt  = 0;
  int wr_cnt    = 0;
  int done_cnt  = 0;
  int lat_sum   = 0;
  int busy_left = 0;
  logic [P_W-1:0] pend_p = '0;

  initial begin
    int lat;
    u_if.core_busy = 1'b0;
    u_if.core_p    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_left      = 0;
        u_if.core_busy = 1'b0;
      end else begin
        // core behaviour: busy for lat cycles after the kick, then result
        if (busy_left > 0) begin
          u_if.core_busy = 1'b1;
          busy_left--;
        end else if (u_if.core_busy) begin
          u_if.core_busy = 1'b0;
          u_if.core_p    = pend_p;
        end
        if (u_if.core_start) begin
          check_eq("kick_col_idx", u_if.col_idx, kick_cnt);
          if (dead_from < 0 || kick_cnt < dead_from) begin
            lat       = $urandom_range(lat_max, lat_min);
            busy_left = lat;
            lat_sum  += lat;
            pend_p    = fixed_p ? P_W'(16'h1000 + kick_cnt) : P_W'($urandom);
            exp_q.push_back(pend_p);
          end
          kick_cnt++;
        end
        // buffer side: writes must be in order j = 0,1,.. with the core result
        if (u_if.p_wr_en) begin
          check_eq("wr_addr", u_if.p_wr_addr, wr_cnt);
          if (exp_q.size() == 0) check_eq("wr_pending", exp_q.size(), 1);
          else                   check_eq("wr_data", u_if.p_wr_data, exp_q.pop_front());
          wr_cnt++;
        end
        if (o_done) begin
          check_eq("busy_with_done", o_busy, 0);
          done_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    kick_cnt = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    lat_sum  = 0;
    exp_q.delete();
  endtask

  // One complete pass, checked against the pass-level reference.
  task automatic run_pass(input int n_req, input bit poke, input bit with_abort);
    int n_eff;
    int k;
    n_eff = (n_req > H_MAX) ? H_MAX : n_req;
    @(negedge clk);
    clear_counts();
    i_start      = 1'b1;
    i_abort      = with_abort;
    i_num_hidden = n_req[HW:0];
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    k = 1;
    check_eq("aborted_cleared", o_aborted, 0);
    check_eq("busy_after_start", o_busy, (n_eff != 0));
    while (!o_done && k < 5000) begin
      @(negedge clk);
      k++;
      // start while busy must be ignored
      if (poke && k == 3) begin
        i_start      = 1'b1;
        i_num_hidden = 7'($urandom_range(20, 1));
      end
      if (poke && k == 4) i_start = 1'b0;
    end
    check_eq("done_seen", o_done, 1);
    check_eq("done_latency", k, (n_eff == 0) ? 1 : 5 * n_eff + lat_sum);
    repeat (2) @(negedge clk);
    check_eq("kick_count", kick_cnt, n_eff);
    check_eq("write_count", wr_cnt, n_eff);
    check_eq("done_count", done_cnt, 1);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("busy_idle", o_busy, 0);
    check_eq("col_idx_hold", u_if.col_idx, (n_eff == 0) ? 0 : n_eff - 1);
  endtask

  task automatic start_raw(input int n_req);
    @(negedge clk);
    clear_counts();
    i_start      = 1'b1;
    i_num_hidden = n_req[HW:0];
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_kick(input int j);
    int k;
    k = 0;
    while (!(u_if.core_start && u_if.col_idx == HW'(j)) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check_eq("reach_kick", u_if.col_idx, j);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"},       o_busy, 0);
    check_eq({tag, "_done"},       o_done, 0);
    check_eq({tag, "_aborted"},    o_aborted, 0);
    check_eq({tag, "_err"},        o_err_timeout, 0);
    check_eq({tag, "_state"},      o_dbg_state, 0);
    check_eq({tag, "_col_idx"},    u_if.col_idx, 0);
    check_eq({tag, "_core_start"}, u_if.core_start, 0);
    check_eq({tag, "_wr_en"},      u_if.p_wr_en, 0);
    check_eq({tag, "_wr_addr"},    u_if.p_wr_addr, 0);
    check_eq({tag, "_wr_data"},    u_if.p_wr_data, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    i_start      = 1'b0;
    i_abort      = 1'b0;
    i_num_hidden = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 4 units, 10-cycle core, p = 0x1000+j: 60 cycles start-to-done
    fixed_p = 1'b1; lat_min = 10; lat_max = 10;
    run_pass(4, 1'b0, 1'b0);
    check_eq("t4_lat_sum", lat_sum, 40);

    // empty pass
    run_pass(0, 1'b0, 1'b0);

    // clamp to H_MAX
    fixed_p = 1'b0; lat_min = 1; lat_max = 3;
    run_pass(100, 1'b0, 1'b0);

    // random passes, spurious start mid-pass, some with abort alongside start
    lat_min = 1; lat_max = 6;
    for (int i = 0; i < 6; i++) begin
      run_pass($urandom_range(12, 1), 1'b1, (i % 2 == 1));
    end

    // abort during WAIT_FALL of j=2
    fixed_p = 1'b1; lat_min = 10; lat_max = 10;
    start_raw(8);
    wait_kick(2);
    repeat (3) @(negedge clk);
    i_abort = 1'b1;
    #1;
    check_eq("abort_no_wr", u_if.p_wr_en, 0);
    check_eq("abort_no_done", o_done, 0);
    @(negedge clk);
    i_abort = 1'b0;
    check_eq("abort_busy", o_busy, 0);
    check_eq("abort_sticky", o_aborted, 1);
    repeat (20) @(negedge clk);
    check_eq("abort_writes", wr_cnt, 2);
    check_eq("abort_done_cnt", done_cnt, 0);
    check_eq("abort_still_set", o_aborted, 1);
    run_pass(1, 1'b0, 1'b0);

    // abort in the KICK cycle suppresses core_start
    lat_min = 2; lat_max = 4;
    start_raw(3);
    wait_kick(1);
    i_abort = 1'b1;
    #1;
    check_eq("kick_abort_start", u_if.core_start, 0);
    @(negedge clk);
    i_abort = 1'b0;
    check_eq("kick_abort_flag", o_aborted, 1);
    repeat (10) @(negedge clk);
    check_eq("kick_abort_writes", wr_cnt, 1);
    check_eq("kick_abort_done", done_cnt, 0);

    // reset mid-pass while stuck in WAIT_RISE at j=2
    fixed_p = 1'b0; dead_from = 2;
    start_raw(5);
    wait_kick(2);
    repeat (3) @(negedge clk);
    check_eq("pre_reset_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    dead_from = -1;
    repeat (3) @(negedge clk);
    check_eq("in_reset_wr_cnt", wr_cnt, 2);
    rst_n = 1'b1;
    run_pass(5, 1'b0, 1'b0);

    // core that never raises busy
    dead_from = 0;
    start_raw(2);
`ifdef RBM_SCHED_TIMEOUT_EN
    k = 1;
    while (o_busy && k < 70000) begin
      @(negedge clk);
      k++;
    end
    check_eq("timeout_cycles", k, 65538);
    check_eq("timeout_err", o_err_timeout, 1);
    check_eq("timeout_aborted", o_aborted, 1);
    check_eq("timeout_busy", o_busy, 0);
`else
    k = 0;
    repeat (3000) begin
      @(negedge clk);
      if (o_busy) k++;
    end
    check_eq("no_wdog_busy_cycles", k, 3000);
    check_eq("no_wdog_err", o_err_timeout, 0);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check_eq("no_wdog_abort", o_aborted, 1);
`endif
    dead_from = -1;
    run_pass(3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rbm_hidden_sched.md
# rbm_hidden_sched

Sequencer for the single-unit RBM core in the hidden-layer pass. It walks hidden index j over 0..num_hidden-1 and, for each j:
- selects weight column j and bias j;
- pulses the core start and waits for the core busy to fall;
- writes the resulting probability p_j into the hidden-probability buffer.

It sits between the host-facing control registers and the core, and replaces bench-driven start pulses.

## Interface
- H_MAX, 64: maximum hidden units; index width HW = $clog2(H_MAX).
- P_W, 16: width of p_j (Q0.16).
- clk  in  1: system clock, all logic rising-edge.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: begin a pass; sampled in IDLE only.
- abort  in  1: cancel pass; highest priority after reset.
- num_hidden  in  HW+1: units to process, sampled at start; values above H_MAX are clamped to H_MAX.
- busy  out  1: high from the cycle after accepted start until return to IDLE.
- done  out  1: one-cycle pulse on normal completion.
- aborted  out  1: sticky; set on abort, cleared on next accepted start.
- col_idx  out  HW: current j; drives weight-column select and bias read address.
- core_start  out  1: one-cycle start pulse to core.
- core_busy  in  1: core busy.
- core_p  in  P_W: core result p_j.
- p_wr_en  out  1: buffer write strobe.
- p_wr_addr  out  HW: write address (= j).
- p_wr_data  out  P_W: registered core_p.
- err_timeout  out  1: sticky watchdog flag (see Configuration).

## Operation
- States: IDLE, SETUP, KICK, WAIT_RISE, WAIT_FALL, WRITE, NEXT.
- IDLE: start=1 latches n = min(num_hidden, H_MAX), clears j and aborted.
  - If n=0, go to IDLE and pulse done the next cycle without touching the core.
  - Otherwise go to SETUP.
- SETUP: one cycle; col_idx=j is stable, giving the bias/weight memories one cycle of read latency. Then KICK.
- KICK: core_start=1 for exactly one cycle. Then WAIT_RISE.
- WAIT_RISE: wait for core_busy=1. Then WAIT_FALL.
- WAIT_FALL: wait for core_busy=0; capture core_p into p_wr_data on the exit edge. Then WRITE.
- WRITE: p_wr_en=1, p_wr_addr=j for one cycle. Then NEXT.
- NEXT:
  - if j==n-1: assert done for one cycle and go to IDLE;
  - else: j<=j+1 and go to SETUP.
- col_idx holds j in every non-IDLE state; in IDLE it holds the last j.
- abort=1 in any non-IDLE state:
  - next state IDLE, aborted<=1, no done, no p_wr_en that cycle;
  - core_start is forced low in that cycle;
  - the core may still finish its computation, and its result is discarded.
- start while busy=1 is ignored. start and abort together in IDLE: start wins, abort ignored.
- j never wraps: counter is HW bits, and n≤H_MAX, so j≤H_MAX-1.

## Timing
- Reset values: busy=0, done=0, aborted=0, col_idx=0, core_start=0, p_wr_en=0, p_wr_addr=0, p_wr_data=0, err_timeout=0, state=IDLE, j=0.
- Asserting rst_n low mid-pass forces all of the above immediately (asynchronous); the buffer sees no further writes.
- Per-unit overhead outside the core: SETUP + KICK + 1 (WAIT_RISE minimum) + WRITE + NEXT = 5 cycles plus core busy time.
- First core_start occurs 2 cycles after the start edge (SETUP, then KICK).
- done is asserted in the cycle after the last WRITE; busy falls in the same cycle done is high.
- p_wr_data is registered, valid only while p_wr_en=1.

## Configuration
- RBM_SCHED_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles spent in WAIT_RISE or WAIT_FALL and reloads on entry to each.
  - Reaching 0xFFFF sets err_timeout (sticky until next accepted start) and takes the abort path (IDLE, aborted=1).
- RBM_SCHED_TIMEOUT_EN undefined:
  - No counter; err_timeout tied 0.
  - WAIT states wait indefinitely.

## Test plan
- num_hidden=4, core model holds busy 10 cycles and returns p=0x1000+j -> writes addr 0..3 with data 0x1000..0x1003, exactly 4 core_start pulses, done once, total 60 cycles start-to-done.
- num_hidden=0 -> no core_start, no p_wr_en, done one cycle after start.
- num_hidden=100 with H_MAX=64 -> 64 writes, last addr 63, done, col_idx never exceeds 63.
- abort during WAIT_FALL of j=2 (num_hidden=8) -> writes only addr 0,1; aborted=1; no done; next start with num_hidden=1 clears aborted and completes.
- rst_n low during WAIT_RISE -> all outputs at reset values immediately; a subsequent start runs cleanly from j=0.
- With RBM_SCHED_TIMEOUT_EN, core model never raises busy -> err_timeout=1 and aborted=1 after 65535 cycles in WAIT_RISE, busy=0. Without the macro -> busy stays 1.
